// File: rtl/display_scan.sv
// display_scan -- time-multiplexed driver for a 4-digit, 7-segment display.
//
// Each digit owns a slot of DIV cycles. A slot opens with BLANK dark cycles
// (so the external registered 4:1 mux has settled onto the new sel), then the
// mux output q_in is captured once, decoded and shown for the rest of the slot.
//
// Parameters
//   DIV    clock cycles per digit slot (4..65535)
//   BLANK  dark cycles at the start of every slot (2..DIV-2)
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous, active-high reset
//   en     scan enable; 0 turns the display dark and freezes the scan
//   q_in   registered mux code: [3:0] hex digit, [4] decimal-point request
//   sel    digit select to the mux (registered)
//   an     anode enables, active-low, one-hot-low while lit (registered)
//   seg    segments {g,f,e,d,c,b,a}, active-low (registered)
//   dp     decimal point, active-low (registered)
//   tick   one-cycle pulse in the cycle whose closing edge advances sel
module display_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] q_in,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       tick
);

  // Binary encoding; 2'b11 is unused and falls back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BLANK = 2'b01,
    S_SHOW  = 2'b10
  } state_t;

  localparam logic [15:0] PC_LAST       = 16'(DIV - 1);
  localparam logic [15:0] PC_BLANK_LAST = 16'(BLANK - 1);

  state_t      state, state_n;
  logic [15:0] pcnt,  pcnt_n;
  logic [1:0]  sel_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Combinational so it is high during the last cycle of the slot, i.e. the
  // cycle whose closing edge advances sel. Gating with en suppresses it when
  // the scan is being frozen on that same edge.
  assign tick = en && (state == S_SHOW) && (pcnt == PC_LAST);

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    sel_n   = sel;
    an_n    = an;
    seg_n   = seg;
    dp_n    = dp;
    if (!en) begin
      // Freeze pcnt/sel where they are; go dark.
      state_n = S_IDLE;
      an_n    = 4'hF;
      seg_n   = 7'h7F;
      dp_n    = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_BLANK;
          pcnt_n  = '0;
          an_n    = 4'hF;
        end
        S_BLANK: begin
          an_n   = 4'hF;
          pcnt_n = pcnt + 16'd1;
          if (pcnt == PC_BLANK_LAST) begin
            // Only sampling point of q_in in the whole slot.
            state_n = S_SHOW;
            seg_n   = seg_decode(q_in[3:0]);
            dp_n    = ~q_in[4];
            an_n    = ~(4'b0001 << sel);
          end
        end
        S_SHOW: begin
          if (pcnt == PC_LAST) begin
            // an goes dark on the same edge sel moves, so a digit is never
            // lit with the wrong select.
            state_n = S_BLANK;
            pcnt_n  = '0;
            sel_n   = sel + 2'd1;
            an_n    = 4'hF;
          end else begin
            pcnt_n = pcnt + 16'd1;
          end
        end
        default: begin
          state_n = S_IDLE;
          an_n    = 4'hF;
          seg_n   = 7'h7F;
          dp_n    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pcnt  <= '0;
      sel   <= 2'b00;
      an    <= 4'hF;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      sel   <= sel_n;
      an    <= an_n;
      seg   <= seg_n;
      dp    <= dp_n;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Testbench for display_scan with DIV=8, BLANK=2.
// Reference model: slot position / digit index / captured code, derived
// directly from the slot timing rules; compared every cycle on the falling edge.
module tb_display_scan;

  localparam int DIV = 8;
  localparam int BL  = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] q_in;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       tick;

  display_scan #(.DIV(DIV), .BLANK(BL)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .q_in (q_in),
    .sel  (sel),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .tick (tick)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check helper ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  bit         m_active = 1'b0;  // scanning (not dark/frozen)
  int         m_pos    = 0;     // cycle index within the current slot
  int         m_dig    = 0;     // digit being scanned
  logic [6:0] m_seg    = 7'h7F;
  logic       m_dp     = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_dig    <= 0;
      m_seg    <= 7'h7F;
      m_dp     <= 1'b1;
    end else if (!en) begin
      m_active <= 1'b0;
      m_seg    <= 7'h7F;
      m_dp     <= 1'b1;
    end else if (!m_active) begin
      m_active <= 1'b1;
      m_pos    <= 0;
    end else begin
      if (m_pos == BL - 1) begin
        m_seg <= dec_tab[q_in[3:0]];
        m_dp  <= ~q_in[4];
      end
      if (m_pos == DIV - 1) m_dig <= (m_dig + 1) % 4;
      m_pos <= (m_pos + 1) % DIV;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin : cmp
    logic [3:0] ea;
    logic       et;
    logic       ok;
    if (chk_on) begin
      ea = (m_active && m_pos >= BL) ? ~(4'b0001 << m_dig) : 4'hF;
      et = m_active && en && (m_pos == DIV - 1);
      chk("an",   32'(an),   32'(ea));
      chk("sel",  32'(sel),  32'(m_dig));
      chk("seg",  32'(seg),  32'(m_seg));
      chk("dp",   32'(dp),   32'(m_dp));
      chk("tick", 32'(tick), 32'(et));
      ok = (an == 4'hF) || (an == ~(4'b0001 << sel));
      chk("an_onehot_sel", 32'(ok), 32'd1);
      if (tick) tick_cnt++;
    end
  end

  // ---------------- driver ----------------
  bit         mux_mode = 1'b1;
  logic [4:0] mux_data [4];
  logic [1:0] last_sel = 2'b00;

  // Advance one clock; inputs change 2 time units after the rising edge.
  // In mux mode q_in mimics a registered 4:1 mux (one cycle behind sel).
  task automatic cycle();
    @(posedge clk);
    #2;
    if (mux_mode) q_in = mux_data[last_sel];
    else          q_in = 5'($urandom);
    last_sel = sel;
  endtask

  task automatic wait_pos(input int dig, input int pos, input string name);
    int budget;
    budget = 200;
    while (!(m_dig == dig && m_pos == pos && m_active) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [6:0] seg_hold;
  logic       dp_hold;
  logic [1:0] sel0;

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    q_in = 5'h00;
    mux_data = '{5'h01, 5'h02, 5'h03, 5'h04};
    #1 rst = 1'b1;
    chk_on = 1'b1;
    // Async reset, before any clock edge has happened.
    #2;
    chk("rst_an",   32'(an),   32'hF);
    chk("rst_seg",  32'(seg),  32'h7F);
    chk("rst_dp",   32'(dp),   32'd1);
    chk("rst_sel",  32'(sel),  32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    en = 1'b1;

    // Digits 1,2,3,4 in turn: 2 dark + 6 lit cycles per slot.
    repeat (3) cycle();
    #1 chk("d0_an", 32'(an), 32'b1110); chk("d0_seg", 32'(seg), 32'b1111001); chk("d0_dp", 32'(dp), 32'd1);
    repeat (8) cycle();
    #1 chk("d1_an", 32'(an), 32'b1101); chk("d1_seg", 32'(seg), 32'b0100100);
    repeat (8) cycle();
    #1 chk("d2_an", 32'(an), 32'b1011); chk("d2_seg", 32'(seg), 32'b0110000);
    repeat (8) cycle();
    #1 chk("d3_an", 32'(an), 32'b0111); chk("d3_seg", 32'(seg), 32'b0011001);
    repeat (6) cycle();
    #1 chk("wrap_an", 32'(an), 32'hF); chk("wrap_sel", 32'(sel), 32'd0);

    // Five full frames: 20 ticks, same position afterwards.
    tick_cnt = 0;
    sel0 = sel;
    repeat (160) cycle();
    #1 chk("frames_ticks", 32'(tick_cnt), 32'd20); chk("frames_sel", 32'(sel), 32'(sel0));

    // Decimal point handling; slot 2 shows F with dp requested.
    mux_data = '{5'h00, 5'h01, 5'h1F, 5'h03};
    repeat (2) cycle();
    #1 chk("dp0_an", 32'(an), 32'b1110); chk("dp0_seg", 32'(seg), 32'b1000000); chk("dp0_dp", 32'(dp), 32'd1);
    repeat (16) cycle();
    #1 chk("f2_an", 32'(an), 32'b1011); chk("f2_seg", 32'(seg), 32'b0001110); chk("f2_dp", 32'(dp), 32'd0);

    // Drop en mid-SHOW on digit 1, then resume.
    wait_pos(1, 4, "en_drop");
    en = 1'b0;
    tick_cnt = 0;
    cycle();
    #1 chk("off_an", 32'(an), 32'hF); chk("off_sel", 32'(sel), 32'd1);
    repeat (10) cycle();
    #1 chk("off_ticks", 32'(tick_cnt), 32'd0); chk("off_sel2", 32'(sel), 32'd1);
    en = 1'b1;
    repeat (2) cycle();
    #1 chk("resume_blank_an", 32'(an), 32'hF);
    cycle();
    #1 chk("resume_an", 32'(an), 32'b1101); chk("resume_seg", 32'(seg), 32'b1111001);

    // Asynchronous reset mid-SHOW on digit 2.
    wait_pos(2, 5, "rst_mid");
    rst = 1'b1;
    #1 chk("arst_an", 32'(an), 32'hF); chk("arst_sel", 32'(sel), 32'd0); chk("arst_seg", 32'(seg), 32'h7F);
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    #1 chk("rel_an", 32'(an), 32'b1110); chk("rel_seg", 32'(seg), 32'b1000000); chk("rel_sel", 32'(sel), 32'd0);

    // q_in toggles every cycle; shown code must stay put through SHOW.
    mux_mode = 1'b0;
    wait_pos(3, BL, "stable");
    seg_hold = seg;
    dp_hold  = dp;
    repeat (DIV - BL - 1) begin
      cycle();
      #1 chk("stable_seg", 32'(seg), 32'(seg_hold)); chk("stable_dp", 32'(dp), 32'(dp_hold));
    end

    // Random q_in, en and occasional reset pulses.
    repeat (800) begin
      cycle();
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end
    en = 1'b1;
    repeat (40) cycle();

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot, legal range 4..65535.
REQ-002 Parameter BLANK, default 2: blanked cycles at the start of each slot, legal range 2..DIV-2.
REQ-003 Port clk  input  1  system clock; the only clock, all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port en  input  1  scan enable; 0 = display dark and scan frozen.
REQ-006 Port q_in  input  5  registered code from the 4:1 digit mux; [3:0] hex digit, [4] decimal-point request.
REQ-007 Port sel  output  2  digit select driven to the mux; registered.
REQ-008 Port an  output  4  anode enables, active-low, an[i] lights digit i; registered.
REQ-009 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low; registered.
REQ-010 Port dp  output  1  decimal point, active-low; registered.
REQ-011 Port tick  output  1  one-cycle pulse on the cycle sel advances.

Function
REQ-012 Prescaler: counter pcnt, 0..DIV-1, increments each cycle while en=1 and state is not IDLE; wraps from DIV-1 to 0.
REQ-013 tick=1 exactly in the cycle pcnt=DIV-1 with en=1; sel increments modulo 4 on that edge, 3 wraps to 0.
REQ-014 States: IDLE, BLANK, SHOW; state register binary-encoded, unused encodings return to IDLE.
REQ-015 IDLE: an=1111, seg=1111111, dp=1; en=1 -> BLANK next cycle with pcnt=0, sel unchanged.
REQ-016 BLANK: an=1111; lasts while pcnt<BLANK; covers the mux's one-cycle register latency after sel changes.
REQ-017 BLANK->SHOW on the edge where pcnt goes BLANK-1 -> BLANK; on that edge q_in is captured, decoded, and loaded into seg/dp; an gets the one-hot-low of sel.
REQ-018 SHOW: an, seg, dp hold steady; on the tick edge -> BLANK with an=1111, seg/dp held.
REQ-019 Decode q_in[3:0] (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-020 dp = ~q_in[4] at capture.
REQ-021 q_in is sampled only at the REQ-017 capture edge; changes at any other time have no effect on outputs.
REQ-022 en 1->0 in any state: next edge -> IDLE, pcnt and sel held, outputs per REQ-015; no tick.
REQ-023 Anode for digit i never lit while sel != i; at most one an bit low in any cycle.
REQ-024 Frame time = 4*DIV cycles; lit time per digit = DIV-BLANK cycles.

Reset
REQ-025 rst=1 forces immediately, independent of clk: state=IDLE, pcnt=0, sel=00, an=1111, seg=1111111, dp=1, tick=0.
REQ-026 rst assertion mid-slot aborts the slot; after release with en=1, first BLANK starts on the next edge with sel=00.
REQ-027 No output glitches to a lit value during or on release of reset.

Verification (DIV=8, BLANK=2)
REQ-028 Reset then en=1, mux fed d1..d4=1,2,3,4 -> an sequence 1110,1101,1011,0111; seg 1111001,0100100,0110000,0011001; each lit 6 cycles, dark 2; tick every 8 cycles.
REQ-029 Run 5 full frames -> sel wraps 3->0, 20 ticks counted, pattern repeats identically.
REQ-030 Digit code F with q_in[4]=1 on slot 2 -> seg=0001110, dp=0, an=1011; slot 0 with q_in[4]=0 -> dp=1.
REQ-031 Drop en at pcnt=4 of SHOW on sel=01 -> next cycle an=1111, tick absent, sel stays 01; raise en -> BLANK 2 cycles, digit 1 relit, pcnt restarts at 0.
REQ-032 Assert rst asynchronously mid-SHOW on sel=10 -> an=1111, sel=00 before next clk edge; release -> scan restarts at digit 0.
REQ-033 Toggle q_in every cycle during SHOW -> seg/dp stable; assertion checks REQ-023 throughout all scenarios.
